// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding, RV32IM opcode/funct7 constants and decode types.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

    // ALU operation encoding understood by the execute-stage ALU
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1111;

    // RV32 major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // funct7 values for the OP major opcode
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic {
        B_RS2 = 1'b0,
        B_IMM = 1'b1
    } b_sel_e;

    typedef struct packed {
        logic is_branch;
        logic is_jump;
        logic is_load;
        logic is_store;
        logic is_muldiv;
    } cls_t;

    // Integer funct3 -> ALU op; alt (instr bit 30) only matters for add/sub and srl/sra
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32IM decode into ALU op, operand selects, immediate and class flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage decides when the result is captured.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [3:0]      alu_control,
    output a_sel_e          a_sel,
    output b_sel_e          b_sel,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rd,
    output logic            reg_write,
    output cls_t            cls,
    output logic [2:0]      br_funct3,
    output logic            legal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] i_imm;
    logic [XLEN-1:0] s_imm;
    logic [XLEN-1:0] u_imm;
    logic [XLEN-1:0] shamt;
    logic            writes;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign i_imm  = XLEN'($signed(instr[31:20]));
    assign s_imm  = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign u_imm  = XLEN'($signed({instr[31:12], 12'b0}));
    assign shamt  = XLEN'(instr[24:20]);

    // Opcode decode; anything unrecognised collapses to a NOP with legal cleared
    always_comb begin
        alu_control = ALU_ADD;
        a_sel       = A_ZERO;
        b_sel       = B_IMM;
        imm         = '0;
        writes      = 1'b0;
        cls         = '0;
        br_funct3   = 3'b000;
        legal       = 1'b1;

        case (opcode)
            OPC_OP: begin
                a_sel  = A_RS1;
                b_sel  = B_RS2;
                writes = 1'b1;
                case (funct7)
                    F7_BASE:   alu_control = alu_from_funct3(funct3, 1'b0);
                    F7_ALT:    alu_control = alu_from_funct3(funct3, 1'b1);
                    F7_MULDIV: cls.is_muldiv = 1'b1;
                    default:   legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                a_sel  = A_RS1;
                writes = 1'b1;
                if (funct3 == 3'd1 || funct3 == 3'd5) begin
                    // Shifts take the 5-bit shamt; bit 30 picks arithmetic right shift
                    imm         = shamt;
                    alu_control = alu_from_funct3(funct3, instr[30]);
                end else begin
                    // No immediate subtract, so bit 30 is ignored here
                    imm         = i_imm;
                    alu_control = alu_from_funct3(funct3, 1'b0);
                end
            end
            OPC_LUI: begin
                alu_control = ALU_LUI;
                imm         = u_imm;
                writes      = 1'b1;
            end
            OPC_AUIPC: begin
                a_sel  = A_PC;
                imm    = u_imm;
                writes = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                // ALU forms the link address pc+4; the target is computed elsewhere
                a_sel       = A_PC;
                imm         = XLEN'(32'd4);
                writes      = 1'b1;
                cls.is_jump = 1'b1;
            end
            OPC_BRANCH: begin
                a_sel         = A_RS1;
                b_sel         = B_RS2;
                cls.is_branch = 1'b1;
                br_funct3     = funct3;
                case (funct3[2:1])
                    2'b10:   alu_control = ALU_SLT;
                    2'b11:   alu_control = ALU_SLTU;
                    default: alu_control = ALU_SUB;
                endcase
            end
            OPC_LOAD: begin
                a_sel       = A_RS1;
                imm         = i_imm;
                writes      = 1'b1;
                cls.is_load = 1'b1;
            end
            OPC_STORE: begin
                a_sel        = A_RS1;
                imm          = s_imm;
                cls.is_store = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            alu_control = ALU_ADD;
            a_sel       = A_ZERO;
            b_sel       = B_IMM;
            imm         = '0;
            writes      = 1'b0;
            cls         = '0;
            br_funct3   = 3'b000;
        end
    end

    assign rd        = writes ? instr[11:7] : 5'd0;
    assign reg_write = writes && (rd != 5'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// Single-entry issue register turning instr + register data into the ALU input bundle.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; held bundle is stable while stalled.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_control,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [XLEN-1:0]  store_data,
    output logic [4:0]       rd,
    output logic             reg_write,
    output logic             is_branch,
    output logic             is_jump,
    output logic             is_load,
    output logic             is_store,
    output logic             is_muldiv,
    output logic [2:0]       br_funct3,
    output logic             illegal,
    output logic [CNT_W-1:0] issue_cnt
);

    logic [3:0]      dec_ctrl;
    a_sel_e          dec_a_sel;
    b_sel_e          dec_b_sel;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      dec_rd;
    logic            dec_reg_write;
    cls_t            dec_cls;
    logic [2:0]      dec_br_funct3;
    logic            dec_legal;
    logic [XLEN-1:0] a_next;
    logic [XLEN-1:0] b_next;
    logic            accept;
    logic            consume;

    alu_op_decode #(.XLEN(XLEN)) u_decode (
        .instr       (instr),
        .alu_control (dec_ctrl),
        .a_sel       (dec_a_sel),
        .b_sel       (dec_b_sel),
        .imm         (dec_imm),
        .rd          (dec_rd),
        .reg_write   (dec_reg_write),
        .cls         (dec_cls),
        .br_funct3   (dec_br_funct3),
        .legal       (dec_legal)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign consume  = out_valid && out_ready;

    // Operand A source select
    always_comb begin
        a_next = '0;
        case (dec_a_sel)
            A_RS1:   a_next = rs1_data;
            A_PC:    a_next = pc;
            default: a_next = '0;
        endcase
    end

    assign b_next = (dec_b_sel == B_RS2) ? rs2_data : dec_imm;

    // Handshake register, sticky illegal flag and consume counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            alu_control <= ALU_ADD;
            alu_a       <= '0;
            alu_b       <= '0;
            store_data  <= '0;
            rd          <= 5'd0;
            reg_write   <= 1'b0;
            is_branch   <= 1'b0;
            is_jump     <= 1'b0;
            is_load     <= 1'b0;
            is_store    <= 1'b0;
            is_muldiv   <= 1'b0;
            br_funct3   <= 3'b000;
            illegal     <= 1'b0;
            issue_cnt   <= '0;
        end else begin
            // Flush wins over both accept and a pending consume
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                alu_control <= dec_ctrl;
                alu_a       <= a_next;
                alu_b       <= b_next;
                store_data  <= rs2_data;
                rd          <= dec_rd;
                reg_write   <= dec_reg_write;
                is_branch   <= dec_cls.is_branch;
                is_jump     <= dec_cls.is_jump;
                is_load     <= dec_cls.is_load;
                is_store    <= dec_cls.is_store;
                is_muldiv   <= dec_cls.is_muldiv;
                br_funct3   <= dec_br_funct3;
                if (!dec_legal) begin
                    illegal <= 1'b1;
                end
            end

            if (consume && !flush) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: decode table, backpressure, flush, illegal, reset.
// Latency: checks outputs one cycle after accept through a scoreboard queue.
// Backpressure: drives out_ready low to hold the bundle and compares it every stalled cycle.
module tb_alu_issue_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       alu_control;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [XLEN-1:0]  store_data;
    logic [4:0]       rd;
    logic             reg_write;
    logic             is_branch;
    logic             is_jump;
    logic             is_load;
    logic             is_store;
    logic             is_muldiv;
    logic [2:0]       br_funct3;
    logic             illegal;
    logic [CNT_W-1:0] issue_cnt;

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .pc          (pc),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_control (alu_control),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .store_data  (store_data),
        .rd          (rd),
        .reg_write   (reg_write),
        .is_branch   (is_branch),
        .is_jump     (is_jump),
        .is_load     (is_load),
        .is_store    (is_store),
        .is_muldiv   (is_muldiv),
        .br_funct3   (br_funct3),
        .illegal     (illegal),
        .issue_cnt   (issue_cnt)
    );

    // cls = {is_branch, is_jump, is_load, is_store, is_muldiv}; lgl = expected legal
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rw;
        logic [4:0]  cls;
        logic [2:0]  bf3;
        logic        lgl;
    } vec_t;

    vec_t             q[$];
    logic             mv;
    logic             mill;
    logic [CNT_W-1:0] mcnt;
    int               n_chk;
    int               n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input logic ordy);
        chk("out_valid", 32'(out_valid), 32'(mv));
        chk("in_ready", 32'(in_ready), 32'(!mv || ordy));
        chk("issue_cnt", 32'(issue_cnt), 32'(mcnt));
        chk("illegal", 32'(illegal), 32'(mill));
        if (mv) begin
            chk("alu_control", 32'(alu_control), 32'(q[0].ctrl));
            chk("alu_a", alu_a, q[0].a);
            chk("alu_b", alu_b, q[0].b);
            chk("store_data", store_data, q[0].rs2);
            chk("rd", 32'(rd), 32'(q[0].rd));
            chk("reg_write", 32'(reg_write), 32'(q[0].rw));
            chk("class", 32'({is_branch, is_jump, is_load, is_store, is_muldiv}), 32'(q[0].cls));
            chk("br_funct3", 32'(br_funct3), 32'(q[0].bf3));
        end
    endtask

    // Drive one cycle of inputs, check current outputs, then advance the model past the edge
    task automatic step(input vec_t v, input logic vld, input logic ordy, input logic fl);
        logic acc;
        logic con;
        @(negedge clk);
        instr     = v.instr;
        pc        = v.pc;
        rs1_data  = v.rs1;
        rs2_data  = v.rs2;
        in_valid  = vld;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_state(ordy);
        con = mv && ordy;
        acc = vld && (!mv || ordy) && !fl;
        if (fl) begin
            mv = 1'b0;
            q.delete();
        end else begin
            if (con) void'(q.pop_front());
            if (acc) begin
                q.push_back(v);
                mv = 1'b1;
                if (!v.lgl) mill = 1'b1;
            end else if (con) begin
                mv = 1'b0;
            end
        end
        if (con && !fl) mcnt = mcnt + 1'b1;
    endtask

    vec_t tbl[14];
    vec_t idle;
    vec_t ill;
    vec_t bad_f7;

    initial begin
        //            instr          pc         rs1           rs2       ctrl     a             b             rd  rw  cls       bf3   lgl
        tbl[0]  = '{32'h002081B3, 32'h100, 32'd5,        32'd7, 4'b0000, 32'd5,        32'd7,        5'd3, 1'b1, 5'b00000, 3'd0, 1'b1}; // add
        tbl[1]  = '{32'h402081B3, 32'h100, 32'd5,        32'd7, 4'b0001, 32'd5,        32'd7,        5'd3, 1'b1, 5'b00000, 3'd0, 1'b1}; // sub
        tbl[2]  = '{32'h4040D193, 32'h100, 32'hF0000000, 32'd7, 4'b1000, 32'hF0000000, 32'd4,        5'd3, 1'b1, 5'b00000, 3'd0, 1'b1}; // srai
        tbl[3]  = '{32'h123452B7, 32'h100, 32'd5,        32'd7, 4'b1111, 32'd0,        32'h12345000, 5'd5, 1'b1, 5'b00000, 3'd0, 1'b1}; // lui
        tbl[4]  = '{32'h00208463, 32'h100, 32'd5,        32'd7, 4'b0001, 32'd5,        32'd7,        5'd0, 1'b0, 5'b10000, 3'd0, 1'b1}; // beq
        tbl[5]  = '{32'h0020C463, 32'h100, 32'd5,        32'd7, 4'b0101, 32'd5,        32'd7,        5'd0, 1'b0, 5'b10000, 3'd4, 1'b1}; // blt
        tbl[6]  = '{32'h00001117, 32'h200, 32'd5,        32'd7, 4'b0000, 32'h200,      32'h1000,     5'd2, 1'b1, 5'b00000, 3'd0, 1'b1}; // auipc
        tbl[7]  = '{32'h008000EF, 32'h300, 32'd5,        32'd7, 4'b0000, 32'h300,      32'd4,        5'd1, 1'b1, 5'b01000, 3'd0, 1'b1}; // jal
        tbl[8]  = '{32'hFFC0A183, 32'h100, 32'd5,        32'd7, 4'b0000, 32'd5,        32'hFFFFFFFC, 5'd3, 1'b1, 5'b00100, 3'd0, 1'b1}; // lw -4
        tbl[9]  = '{32'h0020A423, 32'h100, 32'd5,        32'd7, 4'b0000, 32'd5,        32'd8,        5'd0, 1'b0, 5'b00010, 3'd0, 1'b1}; // sw 8
        tbl[10] = '{32'h022081B3, 32'h100, 32'd5,        32'd7, 4'b0000, 32'd5,        32'd7,        5'd3, 1'b1, 5'b00001, 3'd0, 1'b1}; // mul
        tbl[11] = '{32'h00508013, 32'h100, 32'd5,        32'd7, 4'b0000, 32'd5,        32'd5,        5'd0, 1'b0, 5'b00000, 3'd0, 1'b1}; // addi x0
        tbl[12] = '{32'hFFF0F213, 32'h100, 32'd5,        32'd7, 4'b0011, 32'd5,        32'hFFFFFFFF, 5'd4, 1'b1, 5'b00000, 3'd0, 1'b1}; // andi -1
        tbl[13] = '{32'h0020B1B3, 32'h100, 32'd5,        32'd7, 4'b1001, 32'd5,        32'd7,        5'd3, 1'b1, 5'b00000, 3'd0, 1'b1}; // sltu
        idle    = '{32'h0,        32'h0,   32'd0,        32'd0, 4'b0000, 32'd0,        32'd0,        5'd0, 1'b0, 5'b00000, 3'd0, 1'b1};
        ill     = '{32'h0000007F, 32'h100, 32'd5,        32'd7, 4'b0000, 32'd0,        32'd0,        5'd0, 1'b0, 5'b00000, 3'd0, 1'b0};
        bad_f7  = '{32'h202081B3, 32'h100, 32'd5,        32'd7, 4'b0000, 32'd0,        32'd0,        5'd0, 1'b0, 5'b00000, 3'd0, 1'b0};

        n_chk     = 0;
        n_fail    = 0;
        mv        = 1'b0;
        mill      = 1'b0;
        mcnt      = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        instr     = '0;
        pc        = '0;
        rs1_data  = '0;
        rs2_data  = '0;

        // Reset values
        #12;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst alu_control", 32'(alu_control), 32'd0);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst alu_b", alu_b, 32'd0);
        chk("rst issue_cnt", 32'(issue_cnt), 32'd0);
        chk("rst illegal", 32'(illegal), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back decode table: every cycle is a consume plus accept
        for (int i = 0; i < 14; i++) begin
            step(tbl[i], 1'b1, 1'b1, 1'b0);
        end
        step(idle, 1'b0, 1'b1, 1'b0);
        step(idle, 1'b0, 1'b1, 1'b0);

        // Backpressure: bundle held stable, in_ready low, nothing counted; then flush
        step(tbl[0], 1'b1, 1'b1, 1'b0);
        repeat (3) step(tbl[1], 1'b1, 1'b0, 1'b0);
        step(tbl[1], 1'b1, 1'b0, 1'b1);
        step(idle, 1'b0, 1'b1, 1'b0);

        // Flush during a consume: bundle dropped, incoming dropped, count unchanged
        step(tbl[3], 1'b1, 1'b1, 1'b0);
        step(tbl[4], 1'b1, 1'b1, 1'b1);
        step(idle, 1'b0, 1'b1, 1'b0);

        // Illegal opcode issues a NOP and the flag sticks across later legal traffic
        step(ill, 1'b1, 1'b1, 1'b0);
        step(tbl[0], 1'b1, 1'b1, 1'b0);
        step(tbl[1], 1'b1, 1'b1, 1'b0);
        step(tbl[2], 1'b1, 1'b0, 1'b0);
        step(tbl[2], 1'b1, 1'b0, 1'b0);

        // Asynchronous reset while the SUB bundle is held
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst out_valid", 32'(out_valid), 32'd0);
        chk("arst illegal", 32'(illegal), 32'd0);
        chk("arst issue_cnt", 32'(issue_cnt), 32'd0);
        chk("arst alu_control", 32'(alu_control), 32'd0);
        mv   = 1'b0;
        mill = 1'b0;
        mcnt = '0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Recovery, and an unsupported funct7 on OP also flags illegal
        step(bad_f7, 1'b1, 1'b1, 1'b0);
        step(tbl[13], 1'b1, 1'b1, 1'b0);
        step(idle, 1'b0, 1'b1, 1'b0);
        step(idle, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Decode/issue stage that drives the ALU's inputs. It converts a fetched RV32IM instruction plus register-file read data into a registered {alu_control, alu_a, alu_b} bundle and writeback/branch sideband. The ALU decodes this encoding, so this block must produce it. It sits between register read and execute as a single-entry valid/ready pipeline register with flush.

Parameters:
XLEN, 32, datapath width of pc, operands and immediates.
CNT_W, 32, width of the retired-issue counter.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  upstream holds a valid instruction.
in_ready  out  1  stage can accept this cycle.
instr  in  32  RV32IM instruction word.
pc  in  XLEN  instruction address.
rs1_data  in  XLEN  register-file read data for rs1.
rs2_data  in  XLEN  register-file read data for rs2.
flush  in  1  kill the held and incoming instruction (branch redirect).
out_valid  out  1  registered bundle valid.
out_ready  in  1  execute stage consumes the bundle.
alu_control  out  4  ALU opcode.
alu_a  out  XLEN  ALU operand A.
alu_b  out  XLEN  ALU operand B.
store_data  out  XLEN  rs2_data, for stores.
rd  out  5  destination register.
reg_write  out  1  writeback enable. Forced 0 when rd==0.
is_branch, is_jump, is_load, is_store, is_muldiv  out  1 each  instruction class.
br_funct3  out  3  branch condition for the branch unit.
illegal  out  1  sticky. Set when an unsupported opcode is accepted.
issue_cnt  out  CNT_W  count of bundles consumed (out_valid && out_ready).

Behaviour:
- Reset: out_valid=0, illegal=0, issue_cnt=0. All bundle fields 0 (alu_control=4'b0000).
- in_ready = !out_valid || out_ready (combinational).
- Accept condition: in_valid && in_ready && !flush. On accept the bundle registers next edge and out_valid=1. Latency is 1 cycle.
- Consume without accept: out_valid goes to 0.
- While out_valid && !out_ready, every output holds stable.
- Flush has priority over everything: out_valid=0 next edge, the incoming instruction is dropped, and issue_cnt does not increment for that cycle.
- ALU encoding:
  - ADD=0000, SUB=0001, OR=0010, AND=0011, XOR=0100, SLT=0101, SLL=0110, SRL=0111, SRA=1000, SLTU=1001, LUI=1111 (passes B).
- OP (0110011), funct7=0000000 or 0100000: add/sub, sll, slt, sltu, xor, srl/sra, or, and. A=rs1, B=rs2.
- OP-IMM (0010011): same mapping with B=sign-extended imm[11:0].
  - SUB does not exist for OP-IMM.
  - Shifts use B={27'b0, shamt}. imm[10] (bit 30) selects SRA.
- LUI: ctrl=1111, B={instr[31:12],12'b0}, A=0.
- AUIPC: ADD, A=pc, B=U-immediate.
- JAL/JALR: ADD, A=pc, B=4, is_jump=1.
- BRANCH: reg_write=0, is_branch=1, br_funct3=funct3.
  - BEQ/BNE: SUB, with the zero flag used.
  - BLT/BGE: SLT.
  - BLTU/BGEU: SLTU.
  - A=rs1, B=rs2.
- LOAD/STORE: ADD, A=rs1, B=sign-extended I/S immediate. reg_write=0 for stores.
- M-extension (OP, funct7=0000001): is_muldiv=1, ctrl=0000, A=rs1, B=rs2.
- Any other opcode or funct7:
  - Bundle is issued as a NOP: ctrl=0000, reg_write=0, all class flags 0.
  - illegal sets and stays set until reset.
- issue_cnt increments on each consume. It wraps at 2^CNT_W-1 to 0.
- Simultaneous consume and accept: the new bundle replaces the old one, out_valid stays 1, and issue_cnt increments.
- Reset asserted mid-operation: all state clears asynchronously and the held instruction is lost.

Decomposition:
- Package alu_pkg holds:
  - the ALU_* 4-bit opcode localparams above;
  - RV opcode constants (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE);
  - the funct7 constants.
- The ALU uses the same package.
- Sub-module alu_op_decode: purely combinational instr -> {alu_control, operand selects, immediate, class flags, legal}.
- alu_issue_stage holds only the handshake register, sticky flag and counter.

Test Plan:
1. Reset and no stimulus: out_valid=0, alu_control=0000, issue_cnt=0, in_ready=1.
2. ADD 0x002081B3 and SUB 0x402081B3 with rs1=5, rs2=7 and out_ready=1:
   - ADD: next cycle alu_control=0000, alu_a=5, alu_b=7, rd=3, reg_write=1.
   - SUB: alu_control=0001.
3. SRAI 0x4040D193: ctrl=1000, alu_b=4. LUI 0x123452B7: ctrl=1111, alu_b=0x12345000, rd=5.
4. BEQ 0x00208463: ctrl=0001, is_branch=1, reg_write=0. BLT 0x0020C463: ctrl=0101, br_funct3=100.
5. Backpressure and flush:
   - out_ready=0 for 3 cycles with in_valid=1: outputs stable, in_ready=0, issue_cnt unchanged.
   - Then assert flush: out_valid=0 next cycle and nothing is counted.
6. Illegal opcode 0x0000007F: NOP bundle issued and illegal=1 persists.
   - Assert rst_n=0 mid-hold: out_valid, illegal and issue_cnt clear immediately.
